// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: pipeline register layouts, bus enums and
// the alignment helpers used by both the FSM and the lane formatter.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MSIZE_B = 3'd0,
    MSIZE_H = 3'd1,
    MSIZE_W = 3'd2,
    MSIZE_D = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_LD   = 2'b01,
    MEM_ST   = 2'b10
  } mem_op_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef struct packed {
    mem_op_t    mem_rw;
    msize_t     msize;
    logic       mem_unsigned;
    logic       reg_write;
    logic [4:0] rd_addr;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [63:0] alu_out;
    logic [63:0] srcb;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [63:0] rd;
  } memory_data_t;

  localparam int EXE_W = $bits(execute_data_t);
  localparam int MEM_W = $bits(memory_data_t);

  function automatic logic [2:0] size_mask(msize_t size);
    case (size)
      MSIZE_B: return 3'd0;
      MSIZE_H: return 3'd1;
      MSIZE_W: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic misaligned(msize_t size, logic [2:0] off);
    return (off & size_mask(size)) != 3'd0;
  endfunction

  // Window is computed in 16 bits so an 8-byte access at a nonzero offset simply truncates.
  function automatic logic [7:0] strobe_of(msize_t size, logic [2:0] off);
    logic [15:0] m;
    case (size)
      MSIZE_B: m = 16'h0001;
      MSIZE_H: m = 16'h0003;
      MSIZE_W: m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane formatter: shifts store data onto its byte lanes and
// extracts/extends load data from the raw doubleword.
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  off,
  input  logic        mem_unsigned,
  input  logic [63:0] store_src,
  input  logic [63:0] raw_data,
  output logic [63:0] store_data,
  output logic [7:0]  strobe,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] shifted;

  assign shamt      = {off, 3'b000};
  assign store_data = store_src << shamt;
  assign strobe     = strobe_of(msize_t'(size), off);
  assign shifted    = raw_data >> shamt;

  always_comb begin
    load_data = shifted;
    case (msize_t'(size))
      MSIZE_B: load_data = mem_unsigned ? {56'd0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
      MSIZE_H: load_data = mem_unsigned ? {48'd0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
      MSIZE_W: load_data = mem_unsigned ? {32'd0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: takes one execute-stage record at a time, runs it over the data
// bus if it is an aligned load/store, and hands a writeback record onward.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic TRAP_MISALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [EXE_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [MEM_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_misalign,
  output logic             dreq_valid,
  output logic [63:0]      dreq_addr,
  output logic [2:0]       dreq_size,
  output logic [7:0]       dreq_strobe,
  output logic [63:0]      dreq_data,
  input  logic             dresp_addr_ok,
  input  logic             dresp_data_ok,
  input  logic [63:0]      dresp_data
);

  lsu_state_t    state, state_next;
  execute_data_t in_exe, cap_exe, exe_q;
  memory_data_t  out_md;
  logic          drain_q, drain_next, mis_q, load_en;
  logic          accept, in_mem, in_mis, in_issue, ld_q, st_q, killed;
  logic [63:0]   store_data, load_fmt, load_q;
  logic [7:0]    strobe;

  assign in_exe   = execute_data_t'(in_data);
  assign in_mem   = (in_exe.ctl.mem_rw == MEM_LD) || (in_exe.ctl.mem_rw == MEM_ST);
  assign in_mis   = misaligned(in_exe.ctl.msize, in_exe.alu_out[2:0]);
  assign in_issue = in_mem && !(TRAP_MISALIGN && in_mis);
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready && in_exe.valid && !flush;

  // Without trapping, a misaligned address is pulled down to its natural boundary.
  always_comb begin
    cap_exe = in_exe;
    if (!TRAP_MISALIGN) begin
      cap_exe.alu_out[2:0] = in_exe.alu_out[2:0] & ~size_mask(in_exe.ctl.msize);
    end
  end

  assign ld_q   = exe_q.ctl.mem_rw == MEM_LD;
  assign st_q   = exe_q.ctl.mem_rw == MEM_ST;
  assign killed = drain_q || flush;

  // A flushed request must still finish its bus handshake; drain swallows the response.
  always_comb begin
    state_next = state;
    drain_next = drain_q;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = in_issue ? REQ : DONE;
      end
      REQ: begin
        drain_next = killed;
        if (dresp_addr_ok && dresp_data_ok) begin
          state_next = killed ? IDLE : DONE;
          load_en    = ld_q && !killed;
          drain_next = 1'b0;
        end else if (dresp_addr_ok) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        drain_next = killed;
        if (dresp_data_ok) begin
          state_next = killed ? IDLE : DONE;
          load_en    = ld_q && !killed;
          drain_next = 1'b0;
        end
      end
      DONE: begin
        if (flush) begin
          state_next = IDLE;
        end else if (out_ready) begin
          state_next = accept ? (in_issue ? REQ : DONE) : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      drain_q <= 1'b0;
      mis_q   <= 1'b0;
      exe_q   <= '0;
      load_q  <= '0;
    end else begin
      state   <= state_next;
      drain_q <= drain_next;
      if (accept) begin
        exe_q <= cap_exe;
        mis_q <= TRAP_MISALIGN && in_mis;
      end
      if (load_en) load_q <= load_fmt;
    end
  end

  mem_access_unit_align u_align (
    .size         (exe_q.ctl.msize),
    .off          (exe_q.alu_out[2:0]),
    .mem_unsigned (exe_q.ctl.mem_unsigned),
    .store_src    (exe_q.srcb),
    .raw_data     (dresp_data),
    .store_data   (store_data),
    .strobe       (strobe),
    .load_data    (load_fmt)
  );

  assign dreq_valid   = state == REQ;
  assign dreq_addr    = exe_q.alu_out;
  assign dreq_size    = exe_q.ctl.msize;
  assign dreq_strobe  = st_q ? strobe : 8'd0;
  assign dreq_data    = store_data;
  assign out_valid    = state == DONE;
  assign out_misalign = (state == DONE) && mis_q;

  // Loads that reached the bus return memory data; everything else carries the ALU result.
  always_comb begin
    out_md.valid = exe_q.valid;
    out_md.pc    = exe_q.pc;
    out_md.ctl   = exe_q.ctl;
    out_md.rd    = (ld_q && !mis_q) ? load_q : exe_q.alu_out;
  end

  assign out_data = out_md;

endmodule
